// File: rtl/bit_dec4_timer.sv
// bit_dec4_timer: programmable countdown timer.
//
// This timer counts down once per qualified tick. It gives a one-cycle done pulse
// when the count reaches zero. It can optionally reload itself and restart.
// The decrement datapath is a ripple chain of half-subtractor cells. The LSB
// borrow-in is tied to 1, which makes the chain compute count-1.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   load       capture load_val into count and the reload register (-> IDLE)
//   load_val   initial / reload value
//   start      begin countdown from IDLE
//   tick       decrement qualifier, sampled each clk
//   reload_en  auto-restart from the reload register after expiry
//   count      current count (registered)
//   busy       high while counting (RUN)
//   done       one-cycle expiry pulse (registered)
//   zero       combinational count == 0

module bit_dec4_hsub (
  input  logic a,
  input  logic bin,
  output logic diff,
  output logic bout
);
  assign diff = a ^ bin;
  assign bout = ~a & bin;
endmodule

module bit_dec4_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             tick,
  input  logic             reload_en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  // S_GAP is the quiet cycle between two done pulses. The timer enters it when it
  // auto-reloads a zero value, so a zero-length reload pulses done every other cycle.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] count_dec;
  logic [WIDTH-1:0] borrow;
  logic             borrow_out_unused;
  logic             count_is_one;

  // Ripple half-subtractor chain. The final borrow-out is never needed, because
  // RUN never decrements from zero.
  assign borrow[0] = 1'b1;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_dec
      if (i < WIDTH - 1) begin : g_mid
        bit_dec4_hsub u_hs (
          .a    (count[i]),
          .bin  (borrow[i]),
          .diff (count_dec[i]),
          .bout (borrow[i+1])
        );
      end else begin : g_msb
        bit_dec4_hsub u_hs (
          .a    (count[i]),
          .bin  (borrow[i]),
          .diff (count_dec[i]),
          .bout (borrow_out_unused)
        );
      end
    end
  endgenerate

  assign zero         = (count == '0);
  assign count_is_one = (count == WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      count    <= '0;
      reload_q <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (load) begin
      // load aborts any countdown without producing a done pulse
      state    <= S_IDLE;
      count    <= load_val;
      reload_q <= load_val;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (!zero) begin
              state <= S_RUN;
              busy  <= 1'b1;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (tick) begin
            count <= count_dec;
            if (count_is_one) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          done <= 1'b0;
          if (reload_en) begin
            count <= reload_q;
            if (reload_q != '0) begin
              state <= S_RUN;
              busy  <= 1'b1;
            end else begin
              state <= S_GAP;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_GAP: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_dec4_timer.sv
module tb_bit_dec4_timer;

  localparam int WIDTH = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic             start = 1'b0;
  logic             tick = 1'b0;
  logic             reload_en = 1'b0;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             zero;

  always #5 clk = ~clk;

  bit_dec4_timer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_val  (load_val),
    .start     (start),
    .tick      (tick),
    .reload_en (reload_en),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .zero      (zero)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the timer's mode, the current value and the reload value,
  // held as plain integers.
  typedef enum int {M_IDLE, M_RUN, M_DONE, M_GAP} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_cnt  = 0;
  int    m_rld  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_mode = M_IDLE; m_cnt = 0; m_rld = 0;
    end else if (load) begin
      m_cnt = int'(load_val); m_rld = int'(load_val); m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: if (start) m_mode = (m_cnt > 0) ? M_RUN : M_DONE;
        M_RUN: if (tick) begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) m_mode = M_DONE;
        end
        M_DONE: if (reload_en) begin
          m_cnt  = m_rld;
          m_mode = (m_rld > 0) ? M_RUN : M_GAP;
        end else begin
          m_mode = M_IDLE;
        end
        M_GAP: m_mode = M_DONE;
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic cycle(input logic r, input logic l, input int lv,
                       input logic s, input logic t, input logic re);
    rst = r; load = l; load_val = lv[WIDTH-1:0]; start = s; tick = t; reload_en = re;
    @(posedge clk);
    model_step();
    #1;
    check("count", 32'(count), m_cnt);
    check("busy",  32'(busy),  (m_mode == M_RUN)  ? 1 : 0);
    check("done",  32'(done),  (m_mode == M_DONE) ? 1 : 0);
    check("zero",  32'(zero),  (m_cnt == 0)       ? 1 : 0);
  endtask

  initial begin
    int k;
    // reset
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    check("zero_after_reset", 32'(zero), 1);

    // reset during RUN at count 9, then start with no load -> immediate done
    cycle(0, 1, 9, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // basic countdown from 5
    cycle(0, 1, 5, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 1, 0);

    // gapped ticks
    cycle(0, 1, 3, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) cycle(0, 0, 0, 0, (i % 3) == 2, 0);

    // auto-reload with period 3
    cycle(0, 1, 2, 0, 0, 1);
    cycle(0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 9; i++) cycle(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, 0);

    // reload value 0: done every other cycle
    cycle(0, 1, 0, 0, 0, 1);
    cycle(0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);

    // abort at count 7 with load+start+tick together
    cycle(0, 1, 10, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 0);
    check("abort_pre_count", 32'(count), 7);
    cycle(0, 1, 12, 1, 1, 0);
    check("abort_count", 32'(count), 12);
    check("abort_done", 32'(done), 0);

    // maximum load: exactly MAXV ticks to done, no wrap
    cycle(0, 1, MAXV, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 0);
    k = 1;
    while (k <= 40) begin
      cycle(0, 0, 0, 0, 1, 0);
      if (done) break;
      k++;
    end
    check("max_ticks_to_done", 32'(k), MAXV);
    cycle(0, 0, 0, 0, 1, 0);
    check("max_no_wrap", 32'(count), 0);

    // zero-length start
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // start ignored in RUN at count 1
    cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 1, 0, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 19) == 0),
            int'($urandom_range(0, MAXV)),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 1) == 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
